// File: rtl/fetch_buffer_stage.sv
// fetch_buffer_stage: holds the PC, issues instruction-memory reads and queues
// fetched {instr, pc, pc_plus} entries for decode behind a valid/ready handshake.
// A taken branch (redirect) flushes the queue and reloads the PC.
module fetch_buffer_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     Reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic                     imem_rvalid,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [DATA_W-1:0]        dec_instr,
  output logic [ADDR_W-1:0]        dec_pc,
  output logic [ADDR_W-1:0]        dec_pc_plus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            mem_q [DEPTH];

  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] pc_plus;
  entry_t            head;

  // Handshake and fetch-request decode; pointers wrap naturally since DEPTH is a power of 2.
  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid && dec_ready;
  assign imem_req  = !Reset && !redirect_valid && ((count_q < FULL) || pop);
  assign push      = imem_req && imem_rvalid;
  assign pc_plus   = pc_q + STEP;   // carry out of the top bit is dropped

  assign imem_addr   = pc_q;
  assign head        = mem_q[rd_ptr_q];
  assign dec_instr   = head.instr;
  assign dec_pc      = head.pc;
  assign dec_pc_plus = head.pc_plus;
  assign count       = count_q;

  // Next-state for PC, pointers and occupancy; redirect flushes everything.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_plus;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset overriding redirect.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage write; push is already suppressed during Reset and redirect.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only visible once count marks them valid.
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: imem_rdata, pc: pc_q, pc_plus: pc_plus};
    end
  end

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Bench for fetch_buffer_stage: a table of per-cycle vectors with explicit
// expected outputs, hand-written corner sequences, and a reference model with a
// scoreboard queue of expected decode entries checked every cycle.
module tb_fetch_buffer_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus;
  logic [2:0]  count;

  fetch_buffer_stage #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk(clk), .Reset(Reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pc_plus(dec_pc_plus),
    .count(count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: contents are a fixed scramble of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
  endfunction

  always_comb imem_rdata = instr_of(imem_addr);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus;
  } entry_t;

  typedef struct {
    logic        rst, rv, rdy, rdr;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    int          cnt;
    logic        dv;
    logic [31:0] dpc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  entry_t      sb[$];
  logic [31:0] m_pc;
  logic        exp_pop, exp_push;
  logic        d_rst, d_rdr;
  logic [31:0] d_rpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, rv, rdy, rdr, input logic [31:0] rpc);
    @(negedge clk);
    Reset = rst; imem_rvalid = rv; dec_ready = rdy;
    redirect_valid = rdr; redirect_pc = rpc;
    d_rst = rst; d_rdr = rdr; d_rpc = rpc;
    #1;
  endtask

  // Compare the DUT against the model for the current cycle and decide push/pop.
  task automatic model_check();
    logic exp_valid, exp_req;
    exp_valid = (sb.size() != 0);
    exp_pop   = exp_valid && dec_ready;
    exp_req   = !d_rst && !d_rdr && ((sb.size() < DEPTH) || exp_pop);
    exp_push  = exp_req && imem_rvalid;
    check("m_req",   32'(imem_req),  32'(exp_req));
    check("m_addr",  imem_addr,      m_pc);
    check("m_count", 32'(count),     32'(sb.size()));
    check("m_valid", 32'(dec_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("m_instr",   dec_instr,   sb[0].instr);
      check("m_pc",      dec_pc,      sb[0].pc);
      check("m_pc_plus", dec_pc_plus, sb[0].pc_plus);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (d_rst) begin
      sb.delete(); m_pc = 32'h0;
    end else if (d_rdr) begin
      sb.delete(); m_pc = d_rpc;
    end else begin
      if (exp_pop) void'(sb.pop_front());
      if (exp_push) begin
        sb.push_back('{instr: instr_of(m_pc), pc: m_pc, pc_plus: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input logic rst, rv, rdy, rdr, input logic [31:0] rpc);
    drive(rst, rv, rdy, rdr, rpc);
    model_check();
    tick();
  endtask

  function automatic vec_t mk(input logic rst, rv, rdy, rdr, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr, input int cnt,
                              input logic dv, input logic [31:0] dpc);
    return '{rst: rst, rv: rv, rdy: rdy, rdr: rdr, rpc: rpc,
             req: req, addr: addr, cnt: cnt, dv: dv, dpc: dpc};
  endfunction

  vec_t vecs[$];

  initial begin
    //             rst rv rdy rdr rpc       | req addr          cnt dv dpc
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,     0, 32'h0,         0, 0, 32'h0));   // reset state
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'h0,         0, 0, 32'h0));   // first fetch
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'h4,         1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'h8,         1, 1, 32'h4));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'hC,         1, 1, 32'h8));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,     0, 32'h10,        1, 1, 32'hC));   // mid-run reset
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     1, 32'h0,         0, 0, 32'h0));   // fill
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     1, 32'h4,         1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     1, 32'h8,         2, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     1, 32'hC,         3, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h10,        4, 1, 32'h0));   // full, hold
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h10,        4, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'h10,        4, 1, 32'h0));   // full push+pop
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'h14,        4, 1, 32'h4));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     0, 32'h18,        4, 1, 32'h8));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,     1, 32'h18,        4, 1, 32'h8));   // pop only
    vecs.push_back(mk(0, 1, 0, 1, 32'h100,   0, 32'h18,        3, 1, 32'hC));   // redirect at count 3
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,     1, 32'h100,       0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'h104,       1, 1, 32'h100));
    vecs.push_back(mk(0, 1, 1, 1, 32'h40,    0, 32'h108,       1, 1, 32'h104)); // redirect with ready
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'h40,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,     1, 32'h44,        1, 1, 32'h40));

    Reset = 1'b1; imem_rvalid = 1'b0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    d_rst = 1'b1; d_rdr = 1'b0; d_rpc = 32'h0;
    repeat (2) @(posedge clk);
    sb.delete(); m_pc = 32'h0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rdy, vecs[i].rdr, vecs[i].rpc);
      model_check();
      check($sformatf("v%0d_req", i),   32'(imem_req),  32'(vecs[i].req));
      check($sformatf("v%0d_addr", i),  imem_addr,      vecs[i].addr);
      check($sformatf("v%0d_count", i), 32'(count),     32'(vecs[i].cnt));
      check($sformatf("v%0d_valid", i), 32'(dec_valid), 32'(vecs[i].dv));
      if (vecs[i].dv) begin
        check($sformatf("v%0d_dpc", i),   dec_pc,      vecs[i].dpc);
        check($sformatf("v%0d_dplus", i), dec_pc_plus, vecs[i].dpc + 32'd4);
      end
      tick();
    end

    // Memory wait states at PC 0x20
    cycle(0, 1, 1, 1, 32'h20);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 32'h0);
      model_check();
      check("wait_addr",  imem_addr,  32'h20);
      check("wait_count", 32'(count), 32'd0);
      tick();
    end
    drive(0, 1, 1, 0, 32'h0);
    model_check();
    check("wait_resume_addr", imem_addr, 32'h20);
    tick();
    drive(0, 1, 1, 0, 32'h0);
    model_check();
    check("wait_resume_valid", 32'(dec_valid), 32'd1);
    check("wait_resume_pc",    dec_pc,         32'h20);
    tick();

    // Address wrap at the top of the address space
    cycle(0, 1, 0, 1, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 32'h0);
    model_check();
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 1, 0, 0, 32'h0);
    model_check();
    check("wrap_dec_pc",   dec_pc,      32'hFFFF_FFFC);
    check("wrap_pc_plus",  dec_pc_plus, 32'h0);
    check("wrap_addr1",    imem_addr,   32'h0);
    tick();

    // Reset together with redirect: reset wins
    drive(1, 1, 1, 1, 32'h500);
    model_check();
    check("rst_rdr_req", 32'(imem_req), 32'd0);
    tick();
    drive(0, 1, 1, 0, 32'h0);
    model_check();
    check("rst_rdr_addr",  imem_addr,  32'h0);
    check("rst_rdr_count", 32'(count), 32'd0);
    tick();

    // Long mixed run: pointers wrap many times, order checked by the scoreboard
    for (int i = 0; i < 60; i++) begin
      cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 0, 32'h0);
    end
    for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
